// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch controller: widths, FSM states, buffer entry.
// Define IF_SKID_BUF_EN for a 2-deep instruction buffer; otherwise a single register.
package if_pkg;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;

`ifdef IF_SKID_BUF_EN
  localparam int IBUF_DEPTH = 2;
`else
  localparam int IBUF_DEPTH = 1;
`endif

  localparam int CNT_W = $clog2(IBUF_DEPTH + 1);

  typedef enum logic [1:0] {
    RST_IDLE,
    REQ,
    WAIT,
    DROP
  } if_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bus bundle: imem request/response channel plus the IF/ID handoff.
// master = fetch controller, slave = memory/decode environment.
interface if_fetch_ctrl_if
  import if_pkg::*;
  ();

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               id_ready;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

endinterface

// File: rtl/if_ibuf.sv
// FIFO of fetched {pc, instr}; push visible at head one cycle later, flush beats push/pop.
// Push is ignored when full unless a pop frees the slot in the same cycle.
module if_ibuf
  import if_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  if_entry_t                    i_push_entry,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output if_entry_t                    o_head
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: one outstanding imem request, responses buffered for decode (1 instr / 2 cycles max).
// Requests are withheld while the buffer is full; redirect flushes the buffer and drops in-flight data.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 30'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    o_cur_pc,
  input  logic [PC_W-1:0]    i_next_pc,
  input  logic               i_redirect,
  if_fetch_ctrl_if.master    bus
);

  if_state_t        r_state, w_state_nxt;
  logic [PC_W-1:0]  r_cur_pc, w_cur_pc_nxt;
  logic [PC_W-1:0]  r_req_pc, w_req_pc_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_room;
  logic             w_accept;
  logic [CNT_W-1:0] w_count;
  if_entry_t        w_head;
  if_entry_t        w_push_entry;

  assign w_room   = (w_count < CNT_W'(IBUF_DEPTH));
  assign w_accept = bus.imem_req_valid && bus.imem_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RST_IDLE;
      r_cur_pc <= RESET_PC;
      r_req_pc <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cur_pc <= w_cur_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
    end
  end

  // PC only ever moves to next_pc; increment lives in the next-PC unit.
  always_comb begin
    w_state_nxt  = r_state;
    w_cur_pc_nxt = r_cur_pc;
    w_req_pc_nxt = r_req_pc;
    w_push       = 1'b0;
    case (r_state)
      RST_IDLE: w_state_nxt = REQ;
      REQ: begin
        if (w_accept) begin
          w_cur_pc_nxt = i_next_pc;
          if (i_redirect) begin
            w_state_nxt = DROP;
          end else begin
            w_req_pc_nxt = r_cur_pc;
            w_state_nxt  = WAIT;
          end
        end else if (i_redirect) begin
          w_cur_pc_nxt = i_next_pc;
        end
      end
      WAIT: begin
        if (i_redirect) w_cur_pc_nxt = i_next_pc;
        if (bus.imem_rsp_valid) begin
          w_push      = !i_redirect;
          w_state_nxt = REQ;
        end else if (i_redirect) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (i_redirect) w_cur_pc_nxt = i_next_pc;
        if (bus.imem_rsp_valid) w_state_nxt = REQ;
      end
      default: w_state_nxt = RST_IDLE;
    endcase
  end

  assign w_push_entry = '{pc: r_req_pc, instr: bus.imem_rsp_data};
  assign w_pop        = bus.if_valid && bus.id_ready;

  if_ibuf #(
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (i_redirect),
    .o_count      (w_count),
    .o_head       (w_head)
  );

  assign o_cur_pc           = r_cur_pc;
  assign bus.imem_req_valid = (r_state == REQ) && w_room;
  assign bus.imem_addr      = r_cur_pc;
  assign bus.if_valid       = (w_count != '0);
  assign bus.if_instr       = w_head.instr;
  assign bus.if_pc          = w_head.pc;

endmodule
